// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the 4Kx8 RAM request controller.
// The request bundle is packed {write, addr, wdata}, with write as the MSB.
package ram_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int FIFO_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_ctrl_req_fifo.sv
// In-order request buffer: synchronous FIFO with a registered occupancy count.
// Pointers wrap modulo DEPTH, which must be a power of two.
module req_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 1 + ADDR_W + DATA_W,
  parameter int DEPTH = FIFO_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_dout    = r_mem[r_rp];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wp] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_do_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Request-side controller for a single-port RAM: buffers requests, sequences
// registered CS/WE/OE strobes, drives the shared bus only while writing.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int FIFO_DEPTH = FIFO_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_write_enable,
  output logic                  ram_oe,
  output logic                  busy
);

  localparam int RW = 1 + ADDR_WIDTH + DATA_WIDTH;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_drive;
  logic                  r_resp_valid;

  logic [RW-1:0]         w_push_data;
  logic [RW-1:0]         w_head;
  logic                  w_head_write;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_push_data = {req_write, req_addr, req_wdata};
  assign {w_head_write, w_head_addr, w_head_wdata} = w_head;

  // A push is refused whenever full, even if the head pops this cycle.
  assign req_ready = rst_n & ~w_full;
  assign w_push    = req_valid & req_ready;
  assign w_pop     = (r_state == IDLE) & ~w_empty;

  req_fifo #(
    .WIDTH(RW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_din  (w_push_data),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cs         <= 1'b0;
      r_we         <= 1'b0;
      r_oe         <= 1'b0;
      r_drive      <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_addr  <= w_head_addr;
            r_wdata <= w_head_wdata;
            r_cs    <= 1'b1;
            if (w_head_write) begin
              r_state <= WR;
              r_we    <= 1'b1;
              r_drive <= 1'b1;
            end else begin
              r_state <= RD;
              r_oe    <= 1'b1;
            end
          end
        end
        WR: begin
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_drive <= 1'b0;
          r_state <= IDLE;
        end
        RD: begin
          r_cs         <= 1'b0;
          r_oe         <= 1'b0;
          r_rdata      <= ram_data;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_data         = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
  assign ram_addr         = r_addr;
  assign ram_cs           = r_cs;
  assign ram_write_enable = r_we;
  assign ram_oe           = r_oe;
  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_rdata;
  assign busy             = ~w_empty | (r_state != IDLE);

endmodule
